pipe_reg_chain: RTL and testbench

- Parametrised chain of DEPTH pipeline registers, each WIDTH bits wide with a per-stage valid bit.
- Per-stage flush inserts a bubble. Back-pressure on any stage stalls only the stages upstream of it; bubbles downstream keep draining.
- Replaces the hand-written per-boundary registers between IF/ID/EXE/MEM/WB with a single configurable block.
- Stage contents are exported flat so the hazard and forwarding logic can inspect every in-flight entry.

---
 rtl/pipe_reg_chain.sv | 93 +++++++++
 tb/tb_pipe_reg_chain.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_chain.sv
// Configurable chain of valid-tagged pipeline registers with per-stage flush,
// upstream-only stall propagation and flat export of every in-flight entry.
module pipe_reg_chain #(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  input  logic [WIDTH-1:0]               in_data,
  output logic                           in_ready,
  output logic                           out_valid,
  output logic [WIDTH-1:0]               out_data,
  input  logic                           out_ready,
  input  logic [DEPTH-1:0]               flush,
  output logic [DEPTH-1:0]               stage_valid,
  output logic [DEPTH*WIDTH-1:0]         stage_data,
  output logic [$clog2(DEPTH+1)-1:0]     occupancy
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0] vld_p;
  logic [WIDTH-1:0] data_p [DEPTH];
  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] src_vld;
  logic [WIDTH-1:0] src_data [DEPTH];

  function automatic logic [OCC_W-1:0] popcount(input logic [DEPTH-1:0] v);
    logic [OCC_W-1:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      c = c + OCC_W'(v[i]);
    end
    return c;
  endfunction

  // An empty stage is always ready, so bubbles never block the stages behind them.
  always_comb begin
    logic acc;
    rdy = '0;
    acc = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      acc    = ~vld_p[i] | acc;
      rdy[i] = acc;
    end
  end

  always_comb begin
    src_vld     = '0;
    src_vld[0]  = in_valid;
    src_data[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      src_vld[i]  = vld_p[i-1];
      src_data[i] = data_p[i-1];
    end
  end

  // Stage registers: flush beats load, load beats hold; a moving bubble resets the payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        vld_p[i]  <= 1'b0;
        data_p[i] <= NOP_VALUE;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (flush[i]) begin
          vld_p[i]  <= 1'b0;
          data_p[i] <= NOP_VALUE;
        end else if (rdy[i]) begin
          vld_p[i]  <= src_vld[i];
          data_p[i] <= src_vld[i] ? src_data[i] : NOP_VALUE;
        end
      end
    end
  end

  always_comb begin
    stage_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      stage_data[i*WIDTH +: WIDTH] = data_p[i];
    end
  end

  assign in_ready    = rdy[0];
  assign out_valid   = vld_p[DEPTH-1];
  assign out_data    = data_p[DEPTH-1];
  assign stage_valid = vld_p;
  assign occupancy   = popcount(vld_p);

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed bench for pipe_reg_chain (DEPTH=4, WIDTH=32): streaming, stall,
// bubble compression, flushes and reset with hand-computed expectations.
module tb_pipe_reg_chain;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [31:0]  in_data;
  logic         in_ready;
  logic         out_valid;
  logic [31:0]  out_data;
  logic         out_ready;
  logic [3:0]   flush;
  logic [3:0]   stage_valid;
  logic [127:0] stage_data;
  logic [2:0]   occupancy;

  int total = 0;
  int bad   = 0;

  pipe_reg_chain #(.WIDTH(32), .DEPTH(4), .NOP_VALUE(32'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .flush       (flush),
    .stage_valid (stage_valid),
    .stage_data  (stage_data),
    .occupancy   (occupancy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_stalled(input logic [31:0] base);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_data = base + 32'(k);
      step();
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; flush = '0;
    step(); step();
    rst = 1'b0;
    #1;
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (out_data !== 32'h0) begin bad++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total++; if (stage_valid !== 4'b0000) begin bad++; $display("FAIL reset_stage_valid: got %b want 0000", stage_valid); end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      in_valid = (k < 8);
      in_data  = (k < 8) ? 32'h11 + 32'(k) : 32'h0;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready k=%0d: got %b want 1", k, in_ready); end
      step();
      if (k < 3 || k == 11) begin
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_early_valid k=%0d: got %b want 0", k, out_valid); end
      end else begin
        total++; if (out_valid !== 1'b1 || out_data !== 32'h11 + 32'(k - 3)) begin
          bad++; $display("FAIL stream_out k=%0d: got v=%b d=%h want v=1 d=%h", k, out_valid, out_data, 32'h11 + 32'(k - 3));
        end
      end
      if (k >= 3 && k <= 7) begin
        total++; if (occupancy !== 3'd4) begin bad++; $display("FAIL stream_occ k=%0d: got %0d want 4", k, occupancy); end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_stall_fill();
    int acc;
    acc = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_data = 32'h11 + 32'(acc);
      #1;
      total++; if (in_ready !== (k < 4)) begin bad++; $display("FAIL stall_in_ready k=%0d: got %b want %b", k, in_ready, (k < 4)); end
      if (in_ready) acc++;
      step();
      if (k >= 3) begin
        total++; if (out_valid !== 1'b1 || out_data !== 32'h11) begin
          bad++; $display("FAIL stall_hold k=%0d: got v=%b d=%h want v=1 d=00000011", k, out_valid, out_data);
        end
      end
    end
    total++; if (acc !== 4) begin bad++; $display("FAIL stall_accepts: got %0d want 4", acc); end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      #1;
      total++; if (out_valid !== 1'b1 || out_data !== 32'h11 + 32'(j)) begin
        bad++; $display("FAIL drain j=%0d: got v=%b d=%h want v=1 d=%h", j, out_valid, out_data, 32'h11 + 32'(j));
      end
      step();
    end
    total++; if (out_valid !== 1'b0 || occupancy !== 3'd0) begin
      bad++; $display("FAIL drain_empty: got v=%b occ=%0d want v=0 occ=0", out_valid, occupancy);
    end
  endtask

  task automatic test_bubble_compression();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA1; #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bubble_rdy_a1: got %b want 1", in_ready); end
    step();
    in_valid = 1'b0; in_data = '0;
    for (int k = 0; k < 2; k++) begin
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bubble_rdy_idle k=%0d: got %b want 1", k, in_ready); end
      step();
    end
    in_valid = 1'b1; in_data = 32'hA2; #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bubble_rdy_a2: got %b want 1", in_ready); end
    step();
    in_valid = 1'b0; in_data = '0;
    for (int k = 0; k < 3; k++) begin
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bubble_rdy_pack k=%0d: got %b want 1", k, in_ready); end
      step();
    end
    total++; if (occupancy !== 3'd2) begin bad++; $display("FAIL bubble_occ: got %0d want 2", occupancy); end
    total++; if (stage_valid !== 4'b1100) begin bad++; $display("FAIL bubble_stage_valid: got %b want 1100", stage_valid); end
    total++; if (out_data !== 32'hA1) begin bad++; $display("FAIL bubble_s3: got %h want 000000a1", out_data); end
    total++; if (stage_data[64 +: 32] !== 32'hA2) begin bad++; $display("FAIL bubble_s2: got %h want 000000a2", stage_data[64 +: 32]); end
    out_ready = 1'b1;
    step();
    total++; if (out_valid !== 1'b1 || out_data !== 32'hA2) begin
      bad++; $display("FAIL bubble_drain: got v=%b d=%h want v=1 d=000000a2", out_valid, out_data);
    end
    step();
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL bubble_empty: got %0d want 0", occupancy); end
  endtask

  task automatic test_flush_midstream();
    int idx;
    out_ready = 1'b1;
    for (int s = 0; s < 12; s++) begin
      in_valid = (s < 8);
      in_data  = (s < 8) ? 32'h31 + 32'(s) : 32'h0;
      flush    = (s == 4) ? 4'b0011 : 4'b0000;
      step();
      flush = 4'b0000;
      if (s == 4) begin
        total++; if (stage_valid !== 4'b1100) begin bad++; $display("FAIL flush_stage_valid: got %b want 1100", stage_valid); end
        total++; if (stage_data[63:0] !== 64'h0) begin bad++; $display("FAIL flush_stage_data: got %h want 0", stage_data[63:0]); end
      end
      idx = s - 3;
      if (idx >= 0 && idx <= 7 && idx != 3 && idx != 4) begin
        total++; if (out_valid !== 1'b1 || out_data !== 32'h31 + 32'(idx)) begin
          bad++; $display("FAIL flush_out s=%0d: got v=%b d=%h want v=1 d=%h", s, out_valid, out_data, 32'h31 + 32'(idx));
        end
      end else begin
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_gap s=%0d: got v=%b d=%h want v=0", s, out_valid, out_data); end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_flush_stalled();
    fill_stalled(32'h11);
    total++; if (occupancy !== 3'd4 || out_data !== 32'h11) begin
      bad++; $display("FAIL fstall_full: got occ=%0d d=%h want occ=4 d=00000011", occupancy, out_data);
    end
    flush = 4'b1000;
    step();
    flush = 4'b0000;
    total++; if (occupancy !== 3'd3 || out_valid !== 1'b0 || out_data !== 32'h0) begin
      bad++; $display("FAIL fstall_drop: got occ=%0d v=%b d=%h want occ=3 v=0 d=0", occupancy, out_valid, out_data);
    end
    step();
    total++; if (out_valid !== 1'b1 || out_data !== 32'h12 || occupancy !== 3'd3) begin
      bad++; $display("FAIL fstall_reload: got v=%b d=%h occ=%0d want v=1 d=00000012 occ=3", out_valid, out_data, occupancy);
    end
    total++; if (stage_valid !== 4'b1110) begin bad++; $display("FAIL fstall_valid: got %b want 1110", stage_valid); end
  endtask

  task automatic test_reset_midop();
    in_valid = 1'b1; in_data = 32'h15;
    step();
    total++; if (occupancy !== 3'd4) begin bad++; $display("FAIL rmid_full: got %0d want 4", occupancy); end
    rst = 1'b1; flush = 4'b0101; in_data = 32'h77;
    step();
    rst = 1'b0; flush = 4'b0000; in_valid = 1'b0; in_data = '0;
    #1;
    total++; if (occupancy !== 3'd0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL rmid_ctrl: got occ=%0d v=%b want occ=0 v=0", occupancy, out_valid);
    end
    total++; if (stage_data !== 128'h0) begin bad++; $display("FAIL rmid_data: got %h want 0", stage_data); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rmid_in_ready: got %b want 1", in_ready); end
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'h66;
    for (int s = 1; s <= 4; s++) begin
      step();
      in_valid = 1'b0; in_data = '0;
      total++; if (out_valid !== (s == 4)) begin bad++; $display("FAIL rmid_latency s=%0d: got v=%b want %b", s, out_valid, (s == 4)); end
    end
    total++; if (out_data !== 32'h66) begin bad++; $display("FAIL rmid_first: got %h want 00000066", out_data); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_stall_fill();
    test_bubble_compression();
    test_flush_midstream();
    test_flush_stalled();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
